// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage MIPS-style pipeline: forwarding selects for D/E/M,
// load-use and mult/div stall generation, with a small shadow of the E/M/W destinations.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [4:0] wa_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [1:0] kind_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  output logic [2:0] selRsD,
  output logic [2:0] selRtD,
  output logic [2:0] selRsE,
  output logic [2:0] selRtE,
  output logic [2:0] selRtM,
  output logic       stall,
  output logic       md_busy
);

  typedef enum logic [1:0] {K_NONE, K_LINK, K_ALU, K_LOAD} kind_e;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    kind_e      kind;
    logic       md_start;
    logic       md_div;
  } e_stage_t;

  typedef struct packed {
    logic [4:0] rt;
    logic [4:0] wa;
    kind_e      kind;
  } m_stage_t;

  typedef struct packed {
    logic [4:0] wa;
    kind_e      kind;
  } w_stage_t;

  typedef struct packed {
    logic [2:0] sel;
    logic       stall;
  } dfwd_t;

  e_stage_t e_q, e_d;
  m_stage_t m_q;
  w_stage_t w_q;
  logic [3:0] md_cnt;
  dfwd_t fwd_rs, fwd_rt;
  logic md_stall;

  // A stage only produces a value when it writes a nonzero register.
  function automatic logic hit(input logic [4:0] wa, input kind_e kind, input logic [4:0] r);
    return (r != 5'd0) && (wa == r) && (kind != K_NONE);
  endfunction

  function automatic logic [1:0] tnew_e(input kind_e kind);
    case (kind)
      K_ALU:   return 2'd1;
      K_LOAD:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic dfwd_t fwd_d(input logic [4:0] r, input logic [1:0] tuse,
                                  input e_stage_t e, input m_stage_t m, input w_stage_t w);
    dfwd_t res;
    res = '0;
    if (hit(e.wa, e.kind, r)) begin
      res.sel   = (e.kind == K_LINK) ? 3'd1 : 3'd0;
      res.stall = tuse < tnew_e(e.kind);
    end else if (hit(m.wa, m.kind, r)) begin
      case (m.kind)
        K_LINK:  res.sel = 3'd2;
        K_ALU:   res.sel = 3'd3;
        default: res.sel = 3'd0;
      endcase
      res.stall = (m.kind == K_LOAD) && (tuse < 2'd1);
    end else if (hit(w.wa, w.kind, r)) begin
      res.sel = (w.kind == K_LINK) ? 3'd4 : 3'd5;
    end
    return res;
  endfunction

  function automatic logic [2:0] fwd_e(input logic [4:0] r, input m_stage_t m, input w_stage_t w);
    if (hit(m.wa, m.kind, r)) begin
      case (m.kind)
        K_LINK:  return 3'd1;
        K_ALU:   return 3'd2;
        default: return 3'd0;
      endcase
    end else if (hit(w.wa, w.kind, r)) begin
      return (w.kind == K_LINK) ? 3'd3 : 3'd4;
    end
    return 3'd0;
  endfunction

  assign e_d = '{rs: rs_D, rt: rt_D, wa: wa_D, kind: kind_e'(kind_D),
                 md_start: md_start_D, md_div: md_div_D};

  assign fwd_rs   = fwd_d(rs_D, tuse_rs_D, e_q, m_q, w_q);
  assign fwd_rt   = fwd_d(rt_D, tuse_rt_D, e_q, m_q, w_q);
  assign md_busy  = e_q.md_start | (md_cnt != 4'd0);
  assign md_stall = (md_start_D | md_use_D) & md_busy;

  always_comb begin
    // NOTE: every output gets a value on every path, so no latch can be inferred.
    selRsD = fwd_rs.sel;
    selRtD = fwd_rt.sel;
    selRsE = fwd_e(e_q.rs, m_q, w_q);
    selRtE = fwd_e(e_q.rt, m_q, w_q);
    selRtM = 3'd0;
    if (hit(w_q.wa, w_q.kind, m_q.rt))
      selRtM = (w_q.kind == K_LINK) ? 3'd1 : 3'd2;
    stall = fwd_rs.stall | fwd_rt.stall | md_stall;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      md_cnt <= '0;
    end else begin
      // NOTE: non-blocking, so M and W capture the pre-edge contents of E and M.
      e_q <= stall ? '0 : e_d;
      m_q <= '{rt: e_q.rt, wa: e_q.wa, kind: e_q.kind};
      w_q <= '{wa: m_q.wa, kind: m_q.kind};
      if (e_q.md_start)
        md_cnt <= e_q.md_div ? 4'd10 : 4'd5;
      else if (md_cnt != 4'd0)
        md_cnt <= md_cnt - 4'd1;
    end
  end

`ifndef SYNTHESIS
  // A load in M feeding E means a load-use stall was missed upstream.
  a_no_load_rs_e: assert property (@(posedge clk) disable iff (!rst_n)
    !(hit(m_q.wa, m_q.kind, e_q.rs) && (m_q.kind == K_LOAD)));
  a_no_load_rt_e: assert property (@(posedge clk) disable iff (!rst_n)
    !(hit(m_q.wa, m_q.kind, e_q.rt) && (m_q.kind == K_LOAD)));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected outputs go through a
// scoreboard queue and are compared on the falling edge.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_D, rt_D, wa_D;
  logic [1:0] tuse_rs_D, tuse_rt_D, kind_D;
  logic       md_start_D, md_div_D, md_use_D;
  logic [2:0] selRsD, selRtD, selRsE, selRtE, selRtM;
  logic       stall, md_busy;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] wa;
    logic [1:0] trs;
    logic [1:0] trt;
    logic [1:0] kind;
    logic       ms;
    logic       mdv;
    logic       mu;
  } d_t;

  typedef struct packed {
    logic [2:0] srsd;
    logic [2:0] srtd;
    logic [2:0] srse;
    logic [2:0] srte;
    logic [2:0] srtm;
    logic       stall;
    logic       busy;
  } exp_t;

  localparam exp_t ZERO = '0;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .rs_D(rs_D), .rt_D(rt_D), .wa_D(wa_D),
    .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D), .kind_D(kind_D),
    .md_start_D(md_start_D), .md_div_D(md_div_D), .md_use_D(md_use_D),
    .selRsD(selRsD), .selRtD(selRtD), .selRsE(selRsE), .selRtE(selRtE), .selRtM(selRtM),
    .stall(stall), .md_busy(md_busy)
  );

  function automatic d_t dd(input logic [4:0] rs, rt, wa, input logic [1:0] trs, trt, kind,
                            input logic ms = 1'b0, mdv = 1'b0, mu = 1'b0);
    dd = '{rs, rt, wa, trs, trt, kind, ms, mdv, mu};
  endfunction

  function automatic exp_t ex(input logic [2:0] srsd, srtd, srse, srte, srtm,
                              input logic stl, bsy);
    ex = '{srsd, srtd, srse, srte, srtm, stl, bsy};
  endfunction

  function automatic exp_t outs();
    outs = '{selRsD, selRtD, selRsE, selRtE, selRtM, stall, md_busy};
  endfunction

  task automatic apply(input d_t d);
    rs_D = d.rs; rt_D = d.rt; wa_D = d.wa;
    tuse_rs_D = d.trs; tuse_rt_D = d.trt; kind_D = d.kind;
    md_start_D = d.ms; md_div_D = d.mdv; md_use_D = d.mu;
  endtask

  // Called just after a rising edge: drive D, queue the expectation, check at the falling edge.
  task automatic step(input string tag, input d_t d, input exp_t e);
    exp_t want, got;
    apply(d);
    exp_q.push_back(e);
    @(negedge clk);
    want = exp_q.pop_front();
    got  = outs();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got sRsD=%0d sRtD=%0d sRsE=%0d sRtE=%0d sRtM=%0d stall=%b busy=%b, want sRsD=%0d sRtD=%0d sRsE=%0d sRtE=%0d sRtM=%0d stall=%b busy=%b",
               tag, got.srsd, got.srtd, got.srse, got.srte, got.srtm, got.stall, got.busy,
               want.srsd, want.srtd, want.srse, want.srte, want.srtm, want.stall, want.busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(dd(8, 8, 8, 2'd0, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1));
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (outs() !== ZERO) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h want %h", outs(), ZERO);
    end
    n_cmp++;
    if (dut.md_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_md_cnt: got %0d want 0", dut.md_cnt);
    end
    apply(dd(0, 0, 0, 2'd1, 2'd1, 2'd0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("post_reset", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
  endtask

  task automatic test_alu_alu();
    step("alu c0", dd(1, 2, 8, 2'd1, 2'd1, 2'd2), ZERO);
    step("alu c1", dd(8, 0, 10, 2'd1, 2'd1, 2'd2), ZERO);
    step("alu c2", dd(8, 8, 0, 2'd0, 2'd0, 2'd0), ex(3, 3, 2, 0, 0, 0, 0));
    step("alu c3", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 4, 4, 0, 0, 0));
    step("alu c4", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
  endtask

  task automatic test_store_fwd();
    step("st c0", dd(0, 0, 12, 2'd1, 2'd1, 2'd2), ZERO);
    step("st c1", dd(1, 12, 0, 2'd1, 2'd2, 2'd0), ZERO);
    step("st c2", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 2, 0, 0, 0));
    step("st c3", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 0, 2, 0, 0));
    step("st c4", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
  endtask

  task automatic test_jal_jr();
    step("jal c0", dd(0, 0, 31, 2'd1, 2'd1, 2'd1), ZERO);
    step("jal c1", dd(31, 31, 0, 2'd0, 2'd2, 2'd0), ex(1, 1, 0, 0, 0, 0, 0));
    step("jal c2", dd(31, 0, 0, 2'd0, 2'd1, 2'd0), ex(2, 0, 1, 1, 0, 0, 0));
    step("jal c3", dd(31, 0, 0, 2'd0, 2'd1, 2'd0), ex(4, 0, 3, 0, 1, 0, 0));
    step("jal c4", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
    step("jal c5", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
  endtask

  task automatic test_load_use();
    step("lu_rs c0", dd(1, 0, 9, 2'd1, 2'd1, 2'd3), ZERO);
    step("lu_rs c1", dd(9, 0, 11, 2'd1, 2'd1, 2'd2), ex(0, 0, 0, 0, 0, 1, 0));
    step("lu_rs c2", dd(9, 0, 11, 2'd1, 2'd1, 2'd2), ZERO);
    step("lu_rs c3", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 4, 0, 0, 0, 0));
    step("lu_rs c4", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
    step("lu_rt c0", dd(0, 0, 9, 2'd1, 2'd1, 2'd3), ZERO);
    step("lu_rt c1", dd(0, 9, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 0, 0, 1, 0));
    step("lu_rt c2", dd(0, 9, 0, 2'd1, 2'd1, 2'd0), ZERO);
    step("lu_rt c3", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 4, 0, 0, 0));
    step("lu_rt c4", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
    step("lu_br c0", dd(0, 0, 7, 2'd1, 2'd1, 2'd3), ZERO);
    step("lu_br c1", dd(7, 0, 0, 2'd0, 2'd1, 2'd0), ex(0, 0, 0, 0, 0, 1, 0));
    step("lu_br c2", dd(7, 0, 0, 2'd0, 2'd1, 2'd0), ex(0, 0, 0, 0, 0, 1, 0));
    step("lu_br c3", dd(7, 0, 0, 2'd0, 2'd1, 2'd0), ex(5, 0, 0, 0, 0, 0, 0));
    step("lu_br c4", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
  endtask

  task automatic test_alu_branch();
    step("ab c0", dd(0, 0, 5, 2'd1, 2'd1, 2'd2), ZERO);
    step("ab c1", dd(0, 5, 0, 2'd1, 2'd0, 2'd0), ex(0, 0, 0, 0, 0, 1, 0));
    step("ab c2", dd(0, 5, 0, 2'd1, 2'd0, 2'd0), ex(0, 3, 0, 0, 0, 0, 0));
    step("ab c3", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 4, 0, 0, 0));
    step("ab c4", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
  endtask

  task automatic test_priority();
    step("pri_a c0", dd(0, 0, 6, 2'd1, 2'd1, 2'd2), ZERO);
    step("pri_a c1", dd(0, 0, 6, 2'd1, 2'd1, 2'd1), ZERO);
    step("pri_a c2", dd(6, 0, 0, 2'd0, 2'd1, 2'd0), ex(1, 0, 0, 0, 0, 0, 0));
    step("pri_a c3", dd(6, 0, 0, 2'd1, 2'd1, 2'd0), ex(2, 0, 1, 0, 0, 0, 0));
    step("pri_a c4", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 3, 0, 0, 0, 0));
    step("pri_a c5", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
    step("pri_b c0", dd(0, 0, 6, 2'd1, 2'd1, 2'd2), ZERO);
    step("pri_b c1", dd(0, 0, 6, 2'd1, 2'd1, 2'd3), ZERO);
    step("pri_b c2", dd(6, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 0, 0, 1, 0));
    step("pri_b c3", dd(6, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
    step("pri_b c4", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 4, 0, 0, 0, 0));
    step("pri_b c5", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
  endtask

  task automatic test_zero_reg();
    step("r0 c0", dd(0, 0, 0, 2'd1, 2'd1, 2'd2), ZERO);
    step("r0 c1", dd(0, 0, 0, 2'd0, 2'd0, 2'd0), ZERO);
    step("r0 c2", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
  endtask

  task automatic test_md();
    step("div c0", dd(0, 0, 0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b1, 1'b0), ZERO);
    for (int i = 0; i < 11; i++)
      step($sformatf("div_mflo stall %0d", i), dd(0, 0, 3, 2'd1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1),
           ex(0, 0, 0, 0, 0, 1, 1));
    step("div_mflo go", dd(0, 0, 3, 2'd1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b1), ZERO);
    step("div done", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
    step("mult c0", dd(0, 0, 0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0), ZERO);
    step("mult c1", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 0, 0, 0, 1));
    step("mult c2", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      step($sformatf("mult_mult stall %0d", i), dd(0, 0, 0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0),
           ex(0, 0, 0, 0, 0, 1, 1));
    step("mult_mult go", dd(0, 0, 0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0), ZERO);
    for (int i = 0; i < 6; i++)
      step($sformatf("mult2 busy %0d", i), dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 0, 0, 0, 1));
    step("mult2 done", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
  endtask

  task automatic test_reset_mid_mult();
    step("rmm c0", dd(0, 0, 0, 2'd1, 2'd1, 2'd0, 1'b1, 1'b0, 1'b0), ZERO);
    step("rmm c1", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 0, 0, 0, 1));
    step("rmm c2", dd(0, 0, 4, 2'd1, 2'd1, 2'd2), ex(0, 0, 0, 0, 0, 0, 1));
    step("rmm c3", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ex(0, 0, 0, 0, 0, 0, 1));
    apply(dd(4, 4, 0, 2'd1, 2'd1, 2'd0, 1'b0, 1'b0, 1'b1));
    #2;
    n_cmp++;
    if (outs() !== ex(3, 3, 0, 0, 0, 1, 1) || dut.md_cnt !== 4'd3) begin
      n_bad++;
      $display("FAIL rmm_before: got outs=%h cnt=%0d want outs=%h cnt=3",
               outs(), dut.md_cnt, ex(3, 3, 0, 0, 0, 1, 1));
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (outs() !== ZERO) begin
      n_bad++;
      $display("FAIL rmm_outputs: got %h want %h", outs(), ZERO);
    end
    n_cmp++;
    if (dut.md_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL rmm_md_cnt: got %0d want 0", dut.md_cnt);
    end
    apply(dd(0, 0, 0, 2'd1, 2'd1, 2'd0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("rmm after", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
    step("rmm idle", dd(0, 0, 0, 2'd1, 2'd1, 2'd0), ZERO);
  endtask

  initial begin
    rst_n = 1'b0;
    apply(dd(0, 0, 0, 2'd1, 2'd1, 2'd0));
    test_reset();
    test_alu_alu();
    test_store_fwd();
    test_jal_jr();
    test_load_use();
    test_alu_branch();
    test_priority();
    test_zero_reg();
    test_md();
    test_reset_mid_mult();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
